// File: rtl/aes_package.sv
// aes_package: shared types, round counts and key-length decode for the AES round sequencer
package aes_package;
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUT} aes_round_state_t;
  typedef enum logic [1:0] {KEY128, KEY192, KEY256, KEY_ILLEGAL} aes_key_len_t;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  function automatic logic [3:0] nr_of(input aes_key_len_t kl);
    return kl == KEY256 ? NR_256 : kl == KEY192 ? NR_192 : NR_128;
  endfunction
endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences load, Nr key-gated rounds and the ciphertext handshake of an iterative AES core
module aes_round_ctrl
  import aes_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start_i,
  input  logic [1:0]       key_len_i,
  input  logic             key_ready_i,
  input  logic             out_ready_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             state_load_o,
  output logic             key_load_o,
  output logic             round_en_o,
  output logic             key_step_o,
  output logic             final_round_o,
  output logic [3:0]       round_o,
  output logic             out_valid_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o
);
  aes_round_state_t state;
  aes_key_len_t     key_len;
  logic [3:0]       rnd;
  logic [3:0]       nr;
  logic             err_q;
  logic             idle;
  logic             start_ok;
  logic             last;
  assign key_len  = aes_key_len_t'(key_len_i);
  assign idle     = state == IDLE;
  assign start_ok = idle && start_i && key_len != KEY_ILLEGAL;
  assign last     = rnd == nr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (clear) state <= IDLE;
    else
      case (state)
        IDLE:    if (start_ok) state <= LOAD;
        LOAD:    state <= ROUND;
        ROUND:   if (key_ready_i && last) state <= OUT;
        default: if (out_ready_i) state <= IDLE;
      endcase
  // nr only changes on an accepted start, so mid-block key_len_i edits are invisible
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rnd       <= '0;
      nr        <= '0;
      err_q     <= 1'b0;
      blk_cnt_o <= '0;
    end else if (clear) begin
      rnd       <= '0;
      nr        <= '0;
      err_q     <= 1'b0;
      blk_cnt_o <= '0;
    end else begin
      err_q <= idle && start_i && key_len == KEY_ILLEGAL;
      if (start_ok) begin
        nr  <= nr_of(key_len);
        rnd <= '0;
      end else if (state == LOAD) rnd <= 4'd1;
      else if (round_en_o && !last) rnd <= rnd + 4'd1;
      else if (done_o) rnd <= '0;
      if (done_o) blk_cnt_o <= blk_cnt_o + CNT_W'(1);
    end
  always_comb begin
    ready_o       = idle;
    busy_o        = !idle;
    state_load_o  = state == LOAD;
    key_load_o    = state == LOAD;
    round_en_o    = state == ROUND && key_ready_i;
    key_step_o    = state == ROUND && key_ready_i;
    final_round_o = state == ROUND && last;
    round_o       = state == ROUND ? rnd : 4'd0;
    out_valid_o   = state == OUT;
    done_o        = state == OUT && out_ready_i;
    err_o         = err_q;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed scoreboard bench for the AES round sequencer
module tb_aes_round_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, start = 1'b0, key_ready = 1'b1, out_ready = 1'b1;
  logic [1:0] key_len = 2'd0;
  logic ready, busy, state_load, key_load, round_en, key_step, final_round, out_valid, done, err;
  logic [3:0] round;
  logic [15:0] blk_cnt;
  logic w_ready, w_busy, w_load, w_kload, w_ren, w_kstep, w_final, w_valid, w_done, w_err;
  logic [3:0] w_round;
  logic [1:0] blk_cnt2;
  aes_round_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start), .key_len_i(key_len),
    .key_ready_i(key_ready), .out_ready_i(out_ready), .ready_o(ready), .busy_o(busy),
    .state_load_o(state_load), .key_load_o(key_load), .round_en_o(round_en), .key_step_o(key_step),
    .final_round_o(final_round), .round_o(round), .out_valid_o(out_valid), .done_o(done),
    .err_o(err), .blk_cnt_o(blk_cnt)
  );
  aes_round_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start), .key_len_i(key_len),
    .key_ready_i(key_ready), .out_ready_i(out_ready), .ready_o(w_ready), .busy_o(w_busy),
    .state_load_o(w_load), .key_load_o(w_kload), .round_en_o(w_ren), .key_step_o(w_kstep),
    .final_round_o(w_final), .round_o(w_round), .out_valid_o(w_valid), .done_o(w_done),
    .err_o(w_err), .blk_cnt_o(blk_cnt2)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int vc; int rounds; int vlen; int blk;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, blk_model = 0, last_t0 = 0;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_outs"}, int'({ready, busy, state_load, key_load, round_en, key_step, final_round,
                            round, out_valid, done, err}), 32'h2000);
    chk({n, "_blk"}, int'(blk_cnt), 0);
  endtask
  initial begin
    int rounds = 0, vlen = 0, vrise = 0, fr_last = 0;
    bit prev_v = 0, pend = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_v = 0;
        pend = 0;
        continue;
      end
      if (pend) begin
        chk("blk_cnt", int'(blk_cnt), e.blk & 32'hffff);
        chk("blk_cnt_w2", int'(blk_cnt2), e.blk & 3);
        chk("ready_after_done", int'(ready), 1);
        pend = 0;
      end
      if (state_load) begin
        chk("load_round", int'(round), 0);
        chk("load_key", int'(key_load), 1);
        rounds = 0;
        vlen = 0;
      end
      if (round != 0 && !key_ready) begin
        chk("stall_round", int'(round), rounds + 1);
        chk("stall_en", int'({round_en, key_step}), 0);
      end
      if (round_en) begin
        rounds++;
        chk("round_idx", int'(round), rounds);
        chk("key_step", int'(key_step), 1);
      end
      if (final_round) fr_last = cyc;
      if (out_valid) begin
        vlen++;
        if (!prev_v) vrise = cyc;
      end
      prev_v = out_valid;
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("valid_cycle", vrise, e.vc);
          chk("rounds", rounds, e.rounds);
          chk("valid_len", vlen, e.vlen);
          chk("final_cycle", fr_last, e.vc - 1);
          pend = 1;
        end
      end
    end
  end
  // called at posedge+1; returns at posedge+1 of the first IDLE cycle after the block
  task automatic run_block(input logic [1:0] kl, input int nr, input int st, input int sn,
                           input int od, input int poke, input int ab, input bit ab_rst);
    int t0, r, n;
    exp_t e;
    t0 = cyc;
    last_t0 = t0;
    start = 1'b1;
    key_len = kl;
    key_ready = 1'b1;
    out_ready = od == 0;
    blk_model++;
    e.vc = t0 + nr + 2 + sn;
    e.rounds = nr;
    e.vlen = od + 1;
    e.blk = blk_model;
    sb.push_back(e);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      r = cyc - t0;
      start = r == poke;
      key_len = 2'd0;
      key_ready = !(r >= st && r < st + sn);
      if (ab != 0 && r == ab) begin
        if (ab_rst) reset_n = 1'b0;
        else clear = 1'b1;
      end else if (ab != 0 && r == ab + 1) begin
        clear = 1'b0;
        reset_n = 1'b1;
        out_ready = 1'b1;
        chk_idle("abort");
        void'(sb.pop_back());
        blk_model = 0;
        return;
      end
      if (out_valid) begin
        if (n == od) out_ready = 1'b1;
        n++;
      end
      if (ready && r > 1) begin
        out_ready = 1'b1;
        return;
      end
    end
    chk("block_timeout", 0, 1);
  endtask
  initial begin
    int prev_t0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_block(2'd0, 10, 0, 0, 0, 0, 0, 0);
    run_block(2'd2, 14, 4, 2, 0, 0, 0, 0);
    run_block(2'd1, 12, 0, 0, 5, 5, 0, 0);
    start = 1'b1;
    key_len = 2'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    key_len = 2'd0;
    chk("err_pulse", int'(err), 1);
    chk("err_ready", int'({ready, busy, state_load}), 3'b100);
    @(posedge clk);
    #1;
    chk("err_clear", int'(err), 0);
    chk("err_blk", int'(blk_cnt), blk_model);
    chk("err_ready2", int'(ready), 1);
    run_block(2'd0, 10, 0, 0, 0, 0, 7, 0);
    run_block(2'd0, 10, 0, 0, 3, 0, 12, 1);
    run_block(2'd0, 10, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    blk_model = 0;
    chk_idle("clear_idle");
    for (int b = 0; b < 5; b++) begin
      prev_t0 = last_t0;
      run_block(2'd0, 10, 0, 0, 0, 0, 0, 0);
      if (b > 0) chk("b2b_period", last_t0 - prev_t0, 13);
    end
    @(negedge clk);
    chk("wrap_cnt2", int'(blk_cnt2), 1);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
